// File: rtl/pix_tx_pkg.sv
// Shared types and helpers for the pixel-to-MAC transmit pump.
package pix_tx_pkg;

    localparam int HDR_WORDS_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY_LO,
        ST_PAY_HI
    } pix_state_e;

    // A FIFO entry carries 19 bits; bits 18, 17 and 8 are not pixel data.
    function automatic logic [15:0] pix_half(input logic [18:0] pix);
        return {pix[16:9], pix[7:0]};
    endfunction

endpackage

// File: rtl/pix_hdr_bank.sv
// Header word store: 8x32 register file, one write port, one combinational read port.
module pix_hdr_bank
    import pix_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [31:0] wdat,
    input  logic [2:0]  raddr,
    output logic [31:0] rdat
);

    logic [31:0] mem [HDR_WORDS_MAX];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HDR_WORDS_MAX; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdat;
        end
    end

    assign rdat = mem[raddr];

endmodule

// File: rtl/pix_tx_pump.sv
// Emits one raw MAC frame per start: header bank words, then payload words
// packed from pairs of pixel-FIFO pops, honouring MAC back-pressure.
module pix_tx_pump
    import pix_tx_pkg::*;
#(
    parameter int HDR_WORDS = 4,
    parameter int LEN_W     = 10
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    input  logic             hdr_wr_i,
    input  logic [2:0]       hdr_addr_i,
    input  logic [31:0]      hdr_dat_i,
    input  logic [LEN_W-1:0] payload_words_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      words_sent_o,
    input  logic [18:0]      fifo_dat_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_o,
    output logic [31:0]      tx_data_o,
    output logic             tx_sof_o,
    output logic             tx_we_o,
    input  logic             tx_stop_i
);

    localparam logic [3:0]       HDR_LIM  = 4'(HDR_WORDS);
    localparam logic [2:0]       HDR_LAST = 3'(HDR_WORDS - 1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    pix_state_e       state;
    logic [2:0]       hdr_idx;
    logic [LEN_W-1:0] remaining;
    logic [15:0]      hi_half;
    logic [15:0]      words_sent;
    logic             done;

    logic [31:0] hdr_word;
    logic        hdr_we;
    logic        hdr_phase;
    logic        lo_phase;
    logic        hi_phase;

    assign hdr_phase = (state == ST_HDR);
    assign lo_phase  = (state == ST_PAY_LO);
    assign hi_phase  = (state == ST_PAY_HI);

    // Header writes are only taken while idle so a frame never sees a torn header.
    assign hdr_we = hdr_wr_i && (state == ST_IDLE) && ({1'b0, hdr_addr_i} < HDR_LIM);

    pix_hdr_bank u_hdr_bank (
        .clk   (sys_clk_i),
        .rst   (sys_rst_i),
        .we    (hdr_we),
        .waddr (hdr_addr_i),
        .wdat  (hdr_dat_i),
        .raddr (hdr_idx),
        .rdat  (hdr_word)
    );

    // MAC strobes stay combinational: the MAC expects tx_stop_i honoured in the same cycle.
    assign tx_we_o   = !abort_i && !tx_stop_i && (hdr_phase || (hi_phase && !fifo_empty_i));
    assign fifo_rd_o = !abort_i && !fifo_empty_i && (lo_phase || (hi_phase && !tx_stop_i));
    assign tx_sof_o  = tx_we_o && hdr_phase && (hdr_idx == 3'd0);
    assign tx_data_o = hdr_phase ? hdr_word : {hi_half, pix_half(fifo_dat_i)};

    assign busy_o       = (state != ST_IDLE);
    assign done_o       = done;
    assign words_sent_o = words_sent;

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state      <= ST_IDLE;
            hdr_idx    <= '0;
            remaining  <= '0;
            hi_half    <= '0;
            words_sent <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_i) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            remaining  <= payload_words_i;
                            words_sent <= '0;
                            hdr_idx    <= '0;
                            state      <= ST_HDR;
                        end
                    end
                    ST_HDR: begin
                        if (tx_we_o) begin
                            words_sent <= words_sent + 16'd1;
                            if (hdr_idx == HDR_LAST) begin
                                if (remaining == '0) begin
                                    state <= ST_IDLE;
                                    done  <= 1'b1;
                                end else begin
                                    state <= ST_PAY_LO;
                                end
                            end else begin
                                hdr_idx <= hdr_idx + 3'd1;
                            end
                        end
                    end
                    ST_PAY_LO: begin
                        if (fifo_rd_o) begin
                            hi_half <= pix_half(fifo_dat_i);
                            state   <= ST_PAY_HI;
                        end
                    end
                    ST_PAY_HI: begin
                        // Second pop and the MAC write happen together, so one word per two cycles.
                        if (tx_we_o) begin
                            words_sent <= words_sent + 16'd1;
                            remaining  <= remaining - LEN_ONE;
                            if (remaining == LEN_ONE) begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_PAY_LO;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pix_tx_pump.sv
// Randomised scoreboard bench for pix_tx_pump: expected MAC words are queued
// from a frame-level model and popped by a monitor on every tx_we.
module tb_pix_tx_pump;

    localparam int HDR_WORDS = 4;
    localparam int LEN_W     = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             hdr_wr = 1'b0;
    logic [2:0]       hdr_addr = '0;
    logic [31:0]      hdr_dat = '0;
    logic [LEN_W-1:0] payload = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             busy;
    logic             done;
    logic [15:0]      words_sent;
    logic [18:0]      fifo_dat = '0;
    logic             fifo_empty;
    logic             fifo_rd;
    logic [31:0]      tx_data;
    logic             tx_sof;
    logic             tx_we;
    logic             tx_stop;

    // Clock and reset
    always #5 clk = ~clk;

    pix_tx_pump #(.HDR_WORDS(HDR_WORDS), .LEN_W(LEN_W)) dut (
        .sys_clk_i       (clk),
        .sys_rst_i       (rst),
        .hdr_wr_i        (hdr_wr),
        .hdr_addr_i      (hdr_addr),
        .hdr_dat_i       (hdr_dat),
        .payload_words_i (payload),
        .start_i         (start),
        .abort_i         (abort),
        .busy_o          (busy),
        .done_o          (done),
        .words_sent_o    (words_sent),
        .fifo_dat_i      (fifo_dat),
        .fifo_empty_i    (fifo_empty),
        .fifo_rd_o       (fifo_rd),
        .tx_data_o       (tx_data),
        .tx_sof_o        (tx_sof),
        .tx_we_o         (tx_we),
        .tx_stop_i       (tx_stop)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int pop_base = 0;
    int done_cnt = 0;
    int done_base = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int exp_words = 0;
    bit frame_active = 1'b0;

    logic [32:0] exp_q[$];
    logic [18:0] fifo_q[$];
    logic [18:0] pend_q[$];
    logic [18:0] pix_src[$];
    logic [31:0] hdr_model [8];
    logic [32:0] mon_e;

    logic fifo_none = 1'b1;
    logic fifo_hold = 1'b0;
    logic fifo_rand = 1'b0;
    logic stop_force = 1'b0;
    logic stop_rand = 1'b0;
    logic rnd_stop = 1'b0;
    logic rnd_empty = 1'b0;

    assign fifo_empty = fifo_hold | fifo_none | (fifo_rand & rnd_empty);
    assign tx_stop    = stop_force | (stop_rand & rnd_stop);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] half(input logic [18:0] p);
        return {p[16:9], p[7:0]};
    endfunction

    function automatic logic [18:0] mk_pix(input logic [7:0] hi, input logic [7:0] lo, input logic [2:0] junk);
        return {junk[2], junk[1], hi, junk[0], lo};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: first-word-fall-through, pops on fifo_rd at the edge
    always @(posedge clk) begin
        if (!rst && fifo_rd && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
        #1;
        fifo_none = (fifo_q.size() == 0);
        fifo_dat  = fifo_none ? 19'd0 : fifo_q[0];
        rnd_stop  = ($urandom_range(0, 2) == 0);
        rnd_empty = ($urandom_range(0, 3) == 0);
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_we) begin
                chk("we_under_stop", tx_stop, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", tx_data, 0);
                    chk("unexpected_we_flag", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tx_word", {tx_sof, tx_data}, mon_e);
                end
            end
            if (fifo_rd) chk("pop_when_empty", fifo_empty, 0);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_words_sent", words_sent, exp_words);
                chk("done_exp_left", exp_q.size(), 0);
                chk("done_busy", busy, 0);
                frame_active = 1'b0;
            end
        end
    end

    // Driver tasks
    task automatic hdr_write(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        hdr_wr = 1'b1; hdr_addr = a; hdr_dat = d;
        if (!frame_active && a < 3'(HDR_WORDS)) hdr_model[a] = d;
        @(posedge clk); #1;
        hdr_wr = 1'b0;
    endtask

    task automatic plan_frame(input int len, input int nfill);
        exp_words = HDR_WORDS + len;
        for (int i = 0; i < HDR_WORDS; i++) exp_q.push_back({(i == 0), hdr_model[i]});
        while (pix_src.size() < 2 * len) pix_src.push_back(19'($urandom));
        for (int w = 0; w < len; w++) exp_q.push_back({1'b0, half(pix_src[2*w]), half(pix_src[2*w+1])});
        for (int i = 0; i < 2 * len; i++) begin
            if (i < nfill) fifo_q.push_back(pix_src[i]);
            else pend_q.push_back(pix_src[i]);
        end
        pix_src.delete();
    endtask

    task automatic release_pending();
        while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    endtask

    task automatic do_start(input int len);
        @(posedge clk); #1;
        start = 1'b1; payload = LEN_W'(len);
        start_cyc = cyc; done_base = done_cnt; pop_base = pop_cnt; frame_active = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_cnt == done_base && n < limit) begin
            @(posedge clk);
            n++;
        end
        chk("done_timeout", (done_cnt > done_base), 1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) hdr_model[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", tx_we, 0);
        chk("rst_sof", tx_sof, 0);
        chk("rst_rd", fifo_rd, 0);
        chk("rst_words", words_sent, 0);
        chk("rst_data", tx_data, 0);

        // Header load and zero-length frame
        for (int i = 0; i < HDR_WORDS; i++) hdr_write(3'(i), 32'h11111111 * (i + 1));
        hdr_write(3'd6, 32'hCAFEF00D);
        plan_frame(0, 0);
        do_start(0);
        wait_done(50);
        chk("zero_len_cycles", done_cyc - start_cyc, 5);

        // Payload packing, junk bits set on the second pixel
        pix_src.push_back(mk_pix(8'hAB, 8'hCD, 3'b000));
        pix_src.push_back(mk_pix(8'h12, 8'h34, 3'b111));
        plan_frame(1, 2);
        exp_q[exp_q.size() - 1] = {1'b0, 32'hABCD1234};
        do_start(1);
        wait_done(50);
        chk("pack_cycles", done_cyc - start_cyc, 7);
        chk("pack_pops", pop_cnt - pop_base, 2);
        chk("pack_words", words_sent, 5);

        // MAC back-pressure on header word 2 for five cycles
        plan_frame(1, 2);
        do_start(1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        stop_force = 1'b1;
        pop_base = pop_cnt;
        repeat (5) begin
            @(posedge clk); #1;
        end
        stop_force = 1'b0;
        chk("stall_pops", pop_cnt - pop_base, 0);
        wait_done(50);
        chk("stall_cycles", done_cyc - start_cyc, 12);

        // FIFO underrun after the third pop
        plan_frame(3, 3);
        do_start(3);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("underrun_busy", busy, 1);
        chk("underrun_words", words_sent, 5);
        chk("underrun_pops", pop_cnt - pop_base, 3);
        release_pending();
        wait_done(200);
        chk("underrun_total_pops", pop_cnt - pop_base, 6);

        // Header writes while busy are dropped
        plan_frame(1, 0);
        do_start(1);
        hdr_write(3'd0, 32'hDEADBEEF);
        hdr_write(3'd3, 32'h0BADF00D);
        release_pending();
        wait_done(100);
        plan_frame(0, 0);
        do_start(0);
        wait_done(50);

        // Abort mid-payload with data ready in the abort cycle
        plan_frame(4, 3);
        do_start(4);
        repeat (30) @(posedge clk);
        #1;
        fifo_hold = 1'b1;
        fifo_q.push_back(pend_q.pop_front());
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        fifo_hold = 1'b0;
        @(negedge clk);
        chk("abort_we", tx_we, 0);
        chk("abort_rd", fifo_rd, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        frame_active = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        repeat (10) @(posedge clk);
        chk("abort_no_done", done_cnt, done_base);
        chk("abort_pops", pop_cnt - pop_base, 3);
        chk("abort_words", words_sent, 5);
        exp_q.delete();
        pend_q.delete();
        fifo_hold = 1'b1;
        fifo_q.delete();
        repeat (2) @(posedge clk);
        #1 fifo_hold = 1'b0;

        // Start and abort together while idle
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; payload = LEN_W'(2);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("collide_busy", busy, 0);
        repeat (5) @(posedge clk);
        chk("collide_words", words_sent, 5);
        chk("collide_no_done", done_cnt, done_base);

        // Random frames under random stalls on both sides
        stop_rand = 1'b1;
        fifo_rand = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int len;
            hdr_write(3'($urandom_range(0, 7)), $urandom);
            hdr_write(3'($urandom_range(0, 7)), $urandom);
            len = $urandom_range(0, 6);
            plan_frame(len, 2 * len);
            do_start(len);
            wait_done(3000);
            chk("rand_pops", pop_cnt - pop_base, 2 * len);
        end
        stop_rand = 1'b0;
        fifo_rand = 1'b0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pix_tx_pump.md
# pix_tx_pump

Hardware pixel-to-Ethernet pump between the pixel FIFO read port and the MAC raw transmit interface, both in the `sys_clk_i` domain. It lets the J1 stop moving pixels through memory-mapped I/O. The J1 loads a small header bank and a payload length, then pulses start. The block emits one raw frame: header words first, then payload words packed from pixel-FIFO pops, honouring MAC back-pressure.

## Interface
Parameters:
- `HDR_WORDS`, default 4: number of 32-bit header words per frame; legal range 1..8.
- `LEN_W`, default 10: width of the payload word count.

Ports:
- `sys_clk_i`  in  1  system clock; the only clock.
- `sys_rst_i`  in  1  asynchronous, active-high reset.
- `hdr_wr_i`  in  1  write strobe for the header bank.
- `hdr_addr_i`  in  3  header word index; writes with index ≥ `HDR_WORDS` are dropped.
- `hdr_dat_i`  in  32  header word data.
- `payload_words_i`  in  `LEN_W`  payload length in 32-bit words; sampled on start.
- `start_i`  in  1  one-cycle pulse that begins a frame; ignored while busy.
- `abort_i`  in  1  forces IDLE.
- `busy_o`  out  1  high from the start-accept cycle until done or abort.
- `done_o`  out  1  one-cycle pulse when a frame completes.
- `words_sent_o`  out  16  count of `tx_we_o` pulses in the current or last frame.
- `fifo_dat_i`  in  19  pixel FIFO data, first-word-fall-through; valid whenever `!fifo_empty_i`.
- `fifo_empty_i`  in  1  pixel FIFO empty.
- `fifo_rd_o`  out  1  pop strobe to the pixel FIFO.
- `tx_data_o`  out  32  word to the MAC.
- `tx_sof_o`  out  1  start-of-frame flag; qualified by `tx_we_o`.
- `tx_we_o`  out  1  MAC write strobe.
- `tx_stop_i`  in  1  MAC input buffer full; no write is allowed while it is high.

## Operation
- Pixel extraction: each pop yields the 16-bit half-word `{fifo_dat_i[16:9], fifo_dat_i[7:0]}`. Bits 18, 17 and 8 are discarded.
- Payload packing: the first pop goes to `[31:16]` and the second pop to `[15:0]`.
- States: IDLE, HDR, PAY_LO, PAY_HI.
  - IDLE: on `start_i`, latch `payload_words_i`, clear `words_sent_o` and the header index, then go to HDR.
  - HDR: while `!tx_stop_i`, write header word[idx]. `tx_sof_o`=1 only for idx 0. After word `HDR_WORDS-1`, go to PAY_LO, or to IDLE with `done_o` if the latched length is 0.
  - PAY_LO: when `!fifo_empty_i`, pop and latch the high half, then go to PAY_HI.
  - PAY_HI: when `!fifo_empty_i && !tx_stop_i`, pop and write `{hi, lo}` in the same cycle. Decrement the remaining count. If the count was 1, go to IDLE with `done_o`; otherwise go to PAY_LO.
- `abort_i` takes priority over every transition. Next state is IDLE, with no `tx_we_o` or `fifo_rd_o` in the abort cycle and no `done_o`. A latched high half is discarded.
- `start_i` in the same cycle as `abort_i` while IDLE: abort wins and the start is dropped.
- `hdr_wr_i` while busy is dropped, so the header is stable for the whole frame.
- FIFO empty mid-payload stalls indefinitely. Recovery is only via `abort_i`.
- `words_sent_o` increments on every `tx_we_o`. It does not wrap within a legal frame: the maximum is 8 + 2^`LEN_W` − 1.

## Timing
- Reset values: state IDLE; all outputs 0; header bank 0; counters 0.
- Start accepted at cycle 0 puts `busy_o`=1 at cycle 1. The first `tx_we_o` with `tx_sof_o` comes at cycle 1 if `tx_stop_i`=0.
- Header throughput: 1 word/cycle. Payload throughput: 1 word per 2 cycles.
- `tx_data_o`, `tx_sof_o`, `tx_we_o` and `fifo_rd_o` are combinational from the state registers and `tx_stop_i`/`fifo_empty_i`. No registered delay is permitted, because the MAC samples `tx_stop_i` combinationally.
- `done_o` and the return to IDLE occur in the cycle after the last `tx_we_o`. A new `start_i` is accepted in that same cycle.

## Structure
- Package `pix_tx_pkg`: the state enum, `HDR_WORDS_MAX` = 8, and the half-word extract function (19 bits to 16).
- Sub-module `pix_hdr_bank`: an 8×32 register file with a write port and a combinational read indexed by the header counter.
- The top-level FSM, length counter and word counter live in `pix_tx_pump`.

## Test plan
- Header load and zero-length frame:
  - Stimulus: load 4 header words 0x11111111..0x44444444, `payload_words_i`=0, pulse start.
  - Required response: 4 consecutive `tx_we_o` pulses, SOF on the first only, `done_o` one cycle later, `words_sent_o`=4.
- Payload packing:
  - Stimulus: FIFO preloaded with 0x00AB_CD (bits 16:9=0xAB, 7:0=0xCD), then 0x0012_34; length 1.
  - Required response: payload word 0xABCD1234, two pops, `words_sent_o`=5.
- MAC back-pressure:
  - Stimulus: hold `tx_stop_i` high for 5 cycles during header word 2.
  - Required response: no `tx_we_o` and no pops during the stall; data resumes unchanged; total cycle count grows by 5.
- FIFO underrun:
  - Stimulus: length 3, with the FIFO empty after the 3rd pop.
  - Required response: stalls in PAY_HI; after refill, completes with correct words and exactly 6 pops.
- Abort and start collision:
  - Stimulus: `abort_i` mid-payload.
  - Required response: IDLE next cycle, `busy_o`=0, no `done_o`.
  - Stimulus: `start_i` and `abort_i` together while IDLE.
  - Required response: no frame starts.
- Header locking:
  - Stimulus: `hdr_wr_i` while busy.
  - Required response: ignored; the next frame still sends the old header.
